apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter C_AXI_ADDR_WIDTH, default 32, the paddr and cmd_addr width.
REQ-002 SHALL have parameter C_AXI_DATA_WIDTH, default 32, the pwdata, prdata, cmd_wdata and rsp_rdata width.
REQ-003 SHALL have parameter C_TIMEOUT, default 16, the maximum ACCESS cycles spent waiting for pready; legal range 1..255.
REQ-004 APB_ACLK  input  1  single clock; all logic on its rising edge.
REQ-005 APB_ARESET  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  C_AXI_ADDR_WIDTH  transfer address.
REQ-010 cmd_wdata  input  C_AXI_DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-013 rsp_rdata  output  C_AXI_DATA_WIDTH  read data; 0 for writes.
REQ-014 rsp_err  output  1  1 = pslveer was seen or a timeout occurred.
REQ-015 rsp_timeout  output  1  1 = transfer aborted by timeout.
REQ-016 paddr, pwrite, psel, penable, pwdata  output  (ADDR, 1, 1, 1, DATA)  APB requester signals.
REQ-017 prdata, pready, pslveer  input  (DATA, 1, 1)  APB completer signals.

Function
REQ-018 SHALL implement an FSM with states IDLE, SETUP, ACCESS and RESP.
REQ-019 IDLE: cmd_ready=1; on cmd_valid, SHALL register cmd_write/addr/wdata and go to SETUP on the next edge.
REQ-020 SETUP: psel=1, penable=0, paddr/pwrite/pwdata from the registered command; SHALL go to ACCESS unconditionally after 1 cycle.
REQ-021 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata SHALL hold stable until the transfer ends.
REQ-022 ACCESS with pready=1: SHALL capture prdata (reads only; 0 for writes) and pslveer into the response registers, then go to RESP.
REQ-023 SHALL count ACCESS cycles with pready=0 in an 8-bit counter cleared on entry to SETUP; when the count reaches C_TIMEOUT with pready still 0, SHALL go to RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-024 pready=1 in the same cycle the count reaches C_TIMEOUT SHALL complete normally (pready wins; rsp_timeout=0).
REQ-025 RESP: psel=0, penable=0, rsp_valid=1; SHALL return to IDLE on rsp_ready=1; response fields SHALL hold stable while rsp_ready=0.
REQ-026 cmd_ready SHALL be 0 in SETUP, ACCESS and RESP; at most one transfer is outstanding.
REQ-027 Minimum command-to-response latency: accept edge +3 cycles (SETUP, ACCESS with pready=1, rsp_valid asserted in the next cycle).
REQ-028 Back-to-back throughput: with pready and rsp_ready tied high, one transfer every 4 cycles.
REQ-029 pwdata SHALL be driven to 0 for reads; paddr/pwrite SHALL hold their last values in IDLE and RESP.
REQ-030 psel and penable SHALL be driven from registers (no combinational path from APB inputs to APB outputs).

Reset
REQ-031 While APB_ARESET=1 at an edge: state=IDLE, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0.
REQ-032 cmd_ready SHALL be 0 while APB_ARESET=1 and 1 in the first cycle after its release.
REQ-033 Reset asserted mid-transfer (SETUP/ACCESS/RESP) SHALL abort it with no response issued; psel drops at the reset edge.

Verification
REQ-034 Write addr 0x10, data 0xA5A5_0001, pready=1 in the first ACCESS cycle -> SETUP/ACCESS each 1 cycle, rsp_valid 3 cycles after acceptance, rsp_err=0, rsp_rdata=0.
REQ-035 Read addr 0x20, pready low for 3 cycles, then high with prdata=0xDEAD_BEEF -> ACCESS lasts 4 cycles, paddr stable throughout, rsp_rdata=0xDEAD_BEEF.
REQ-036 Read with pslveer=1 at pready=1 -> rsp_err=1, rsp_timeout=0.
REQ-037 C_TIMEOUT=4, pready held 0 -> exit after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1; pready=1 on the 4th cycle -> normal completion.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp fields stable, cmd_ready=0, new cmd_valid not accepted.
REQ-039 APB_ARESET pulsed during ACCESS -> next cycle psel=0, penable=0, rsp_valid=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding command/response to APB requester bridge with pready timeout
module apb_master_bridge #(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT = 16
) (
  input  logic                        APB_ACLK,
  input  logic                        APB_ARESET,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [C_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic                        rsp_err,
  output logic                        rsp_timeout,
  output logic [C_AXI_ADDR_WIDTH-1:0] paddr,
  output logic                        pwrite,
  output logic                        psel,
  output logic                        penable,
  output logic [C_AXI_DATA_WIDTH-1:0] pwdata,
  input  logic [C_AXI_DATA_WIDTH-1:0] prdata,
  input  logic                        pready,
  input  logic                        pslveer
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [7:0] cnt;
  logic accept, done, expire;
  assign accept = state == IDLE && cmd_valid;
  assign done = state == ACCESS && pready;
  assign expire = state == ACCESS && !pready && cnt + 8'd1 == 8'(C_TIMEOUT);
  assign cmd_ready = state == IDLE && !APB_ARESET;
  assign rsp_valid = state == RESP;
  // next-state selection; pready beats the timeout when both land in the same cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cmd_valid ? SETUP : IDLE;
      SETUP:   state_nx = ACCESS;
      ACCESS:  state_nx = (done || expire) ? RESP : ACCESS;
      default: state_nx = rsp_ready ? IDLE : RESP;
    endcase
  end
  // state register
  always_ff @(posedge APB_ACLK) begin
    if (APB_ARESET) state <= IDLE;
    else state <= state_nx;
  end
  // APB outputs and response fields, all registered so no APB input reaches an APB output combinationally
  always_ff @(posedge APB_ACLK) begin
    if (APB_ARESET) begin
      psel <= 1'b0;
      penable <= 1'b0;
      paddr <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      cnt <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      psel <= state_nx == SETUP || state_nx == ACCESS;
      penable <= state_nx == ACCESS;
      if (accept) begin
        paddr <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_write ? cmd_wdata : '0;
      end
      cnt <= accept ? 8'd0 : (state == ACCESS && !pready) ? cnt + 8'd1 : cnt;
      if (done) begin
        rsp_rdata <= pwrite ? '0 : prdata;
        rsp_err <= pslveer;
        rsp_timeout <= 1'b0;
      end else if (expire) begin
        rsp_rdata <= '0;
        rsp_err <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: table-driven directed checks of the APB bridge plus stall and reset sequences
module tb_apb_master_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, prdata = '0;
  logic pready = 1'b0, pslveer = 1'b0;
  logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, pwrite, psel, penable;
  logic [31:0] rsp_rdata, paddr, pwdata;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(.C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32), .C_TIMEOUT(4)) dut (
    .APB_ACLK(clk), .APB_ARESET(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .paddr(paddr), .pwrite(pwrite),
    .psel(psel), .penable(penable), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslveer(pslveer)
  );

  typedef struct {
    logic wr;
    logic [31:0] addr, wdata, prd;
    logic slv;
    int wt;
    logic [31:0] e_rdata;
    logic e_err, e_to;
    int e_acc;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer a command, follow it through SETUP and ACCESS with a completer that waits v.wt cycles, stop in RESP
  task automatic run_to_resp(input vec_t v);
    int n;
    logic [31:0] e_pw;
    e_pw = v.wr ? v.wdata : 32'h0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("setup_psel_penable", {30'h0, psel, penable}, 32'h2);
    chk("setup_paddr", paddr, v.addr);
    chk("setup_pwrite", {31'h0, pwrite}, {31'h0, v.wr});
    chk("setup_pwdata", pwdata, e_pw);
    chk("setup_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    n = 0;
    while (penable && n < 20) begin
      chk("access_psel", {31'h0, psel}, 32'h1);
      chk("access_paddr", paddr, v.addr);
      chk("access_pwdata", pwdata, e_pw);
      pready = n >= v.wt;
      prdata = v.prd;
      pslveer = v.slv;
      @(negedge clk);
      n++;
    end
    pready = 1'b0; pslveer = 1'b0; prdata = 32'h0;
    chk("access_cycles", n, v.e_acc);
    chk("resp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("resp_psel_penable", {30'h0, psel, penable}, 32'h0);
    chk("resp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("resp_rdata", rsp_rdata, v.e_rdata);
    chk("resp_err", {31'h0, rsp_err}, {31'h0, v.e_err});
    chk("resp_timeout", {31'h0, rsp_timeout}, {31'h0, v.e_to});
    chk("resp_paddr_hold", paddr, v.addr);
  endtask

  task automatic finish_resp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_resp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("post_resp_cmd_ready", {31'h0, cmd_ready}, 32'h1);
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h10, 32'hA5A5_0001, 32'h0,         1'b0, 0,  32'h0,         1'b0, 1'b0, 1};
    tbl[1] = '{1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF, 1'b0, 3,  32'hDEAD_BEEF, 1'b0, 1'b0, 4};
    tbl[2] = '{1'b0, 32'h24, 32'h1111_2222, 32'h1234_5678, 1'b1, 0,  32'h1234_5678, 1'b1, 1'b0, 1};
    tbl[3] = '{1'b0, 32'h30, 32'h0,         32'hCAFE_F00D, 1'b0, 99, 32'h0,         1'b1, 1'b1, 4};
    tbl[4] = '{1'b1, 32'h40, 32'h0F0F_0F0F, 32'hFFFF_0000, 1'b1, 2,  32'h0,         1'b1, 1'b0, 3};
    tbl[5] = '{1'b1, 32'h44, 32'h8000_0001, 32'h5555_AAAA, 1'b0, 99, 32'h0,         1'b1, 1'b1, 4};
    tbl[6] = '{1'b0, 32'h50, 32'h0,         32'h0BAD_F00D, 1'b0, 1,  32'h0BAD_F00D, 1'b0, 1'b0, 2};
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rst_psel_penable", {30'h0, psel, penable}, 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwrite", {31'h0, pwrite}, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_rsp", {28'h0, rsp_valid, rsp_err, rsp_timeout, 1'b0}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("release_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    for (int i = 0; i < 7; i++) begin
      run_to_resp(tbl[i]);
      finish_resp();
    end
    run_to_resp(tbl[1]);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h99; cmd_wdata = 32'h7777_7777;
    repeat (5) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("stall_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("stall_err", {30'h0, rsp_err, rsp_timeout}, 32'h0);
      chk("stall_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      chk("stall_paddr", paddr, 32'h20);
      chk("stall_psel", {31'h0, psel}, 32'h0);
    end
    cmd_valid = 1'b0;
    finish_resp();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_access", {30'h0, psel, penable}, 32'h3);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_psel_penable", {30'h0, psel, penable}, 32'h0);
    chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("abort_cmd_ready_in_rst", {31'h0, cmd_ready}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_release_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("abort_release_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    run_to_resp(tbl[6]);
    finish_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
